wb_stage: RTL and testbench



---
 rtl/wb_stage.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_wb_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// ============================================================================
// Module   : wb_stage
// Brief    : Writeback stage. Merges ALU results (queued) and load returns
//            into one register-file write per cycle and keeps a per-register
//            pending scoreboard for decode hazard stalls.
//            Optional macro WB_BYPASS_EN adds rs0/rs1 forwarding outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage #(
  parameter int QDEPTH = 2,
  parameter int NREG   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ex_valid,
  output logic        o_ex_ready,
  input  logic        i_ex_is_load,
  input  logic [3:0]  i_ex_dest,
  input  logic [15:0] i_ex_data,
  input  logic        i_ex_quarter,
  input  logic [1:0]  i_ex_qsel,
  input  logic        i_mem_rvalid,
  input  logic [15:0] i_mem_rdata,
  output logic        o_rf_write,
  output logic [3:0]  o_rf_writeReg,
  output logic [15:0] o_rf_writeData,
  output logic        o_rf_set_quarter,
  output logic [1:0]  o_rf_qsel,
  input  logic [3:0]  i_id_rs0,
  input  logic [3:0]  i_id_rs1,
  input  logic [3:0]  i_id_rd,
`ifdef WB_BYPASS_EN
  output logic        o_fwd0_hit,
  output logic [15:0] o_fwd0_data,
  output logic        o_fwd1_hit,
  output logic [15:0] o_fwd1_data,
`endif
  output logic        o_hz_stall,
  output logic        o_err_spurious
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CW-1:0] c_QDEPTH = CW'(QDEPTH);
  localparam logic [PW-1:0] c_QLAST  = PW'(QDEPTH - 1);
  localparam logic [4:0]    c_NREG5  = 5'(NREG);

  typedef struct packed {
    logic [3:0]  dest;
    logic [15:0] data;
    logic        quarter;
    logic [1:0]  qsel;
  } wb_entry_t;

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_LOAD_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  wb_entry_t   r_mem [QDEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [3:0]  r_ld_dest;
  logic        r_ld_quarter;
  logic [1:0]  r_ld_qsel;

  logic [NREG-1:0] r_pend;
  logic        r_err_spurious;

  logic        r_rf_write;
  logic [3:0]  r_rf_writeReg;
  logic [15:0] r_rf_writeData;
  logic        r_rf_set_quarter;
  logic [1:0]  r_rf_qsel;

  logic        w_ready;
  logic        w_acc;
  logic        w_acc_alu;
  logic        w_acc_load;
  logic        w_ld_ret;
  logic        w_spurious;
  logic        w_ld_capture;
  logic        w_q_empty;
  logic        w_pop;
  logic        w_bypass;
  logic        w_push;
  logic        w_wr_any;
  logic        w_wr_valid;
  logic        w_acc_tracked;
  wb_entry_t   w_in;
  wb_entry_t   w_wr;
  logic        w_p0;
  logic        w_p1;
  logic        w_prd;
  logic        w_hit0;
  logic        w_hit1;

  // ---------------- handshake ----------------
  assign w_q_empty  = (r_count == '0);
  assign w_ready    = (r_count < c_QDEPTH) & ~(i_ex_is_load & (r_state == S_LOAD_WAIT));
  assign w_acc      = i_ex_valid & w_ready;
  assign w_acc_alu  = w_acc & ~i_ex_is_load;
  assign w_acc_load = w_acc & i_ex_is_load;
  assign w_in       = '{dest: i_ex_dest, data: i_ex_data,
                        quarter: i_ex_quarter, qsel: i_ex_qsel};
  assign w_acc_tracked = w_acc & ({1'b0, i_ex_dest} < c_NREG5);

  // ---------------- load FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ld_ret     = 1'b0;
    w_spurious   = 1'b0;
    w_ld_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_spurious = i_mem_rvalid;
        if (w_acc_load) begin
          w_ld_capture = 1'b1;
          w_state_nxt  = S_LOAD_WAIT;
        end
      end
      S_LOAD_WAIT: begin
        if (i_mem_rvalid) begin
          w_ld_ret    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_dest    <= '0;
      r_ld_quarter <= 1'b0;
      r_ld_qsel    <= '0;
    end else if (w_ld_capture) begin
      r_ld_dest    <= i_ex_dest;
      r_ld_quarter <= i_ex_quarter;
      r_ld_qsel    <= i_ex_qsel;
    end
  end

  // ---------------- write arbitration ----------------
  // An ALU result arriving at an empty queue with no load return goes
  // straight to the rf outputs instead of taking a queue slot.
  assign w_pop    = ~w_ld_ret & ~w_q_empty;
  assign w_bypass = ~w_ld_ret & w_q_empty & w_acc_alu;
  assign w_push   = w_acc_alu & ~w_bypass;
  assign w_wr_any = w_ld_ret | w_pop | w_bypass;

  always_comb begin
    w_wr = w_in;
    if (w_ld_ret) begin
      w_wr = '{dest: r_ld_dest, data: i_mem_rdata,
               quarter: r_ld_quarter, qsel: r_ld_qsel};
    end else if (w_pop) begin
      w_wr = r_mem[r_rd_ptr];
    end
  end

  assign w_wr_valid = w_wr_any & ({1'b0, w_wr.dest} < c_NREG5);

  // ---------------- ALU queue ----------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_QLAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_QLAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- rf outputs ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_write       <= 1'b0;
      r_rf_writeReg    <= '0;
      r_rf_writeData   <= '0;
      r_rf_set_quarter <= 1'b0;
      r_rf_qsel        <= '0;
    end else begin
      r_rf_write <= w_wr_valid;
      if (w_wr_valid) begin
        r_rf_writeReg    <= w_wr.dest;
        r_rf_writeData   <= w_wr.data;
        r_rf_set_quarter <= w_wr.quarter;
        r_rf_qsel        <= w_wr.qsel;
      end
    end
  end

  // ---------------- scoreboard ----------------
  // A bit clears when its write leaves the rf outputs; a same-cycle
  // acceptance to that register wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (r_rf_write && (r_rf_writeReg == 4'(k))) begin
          r_pend[k] <= 1'b0;
        end
        if (w_acc_tracked && (i_ex_dest == 4'(k))) begin
          r_pend[k] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_spurious <= 1'b0;
    end else if (w_spurious) begin
      r_err_spurious <= 1'b1;
    end
  end

  always_comb begin
    w_p0  = 1'b0;
    w_p1  = 1'b0;
    w_prd = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      if (i_id_rs0 == 4'(k)) w_p0  = r_pend[k];
      if (i_id_rs1 == 4'(k)) w_p1  = r_pend[k];
      if (i_id_rd  == 4'(k)) w_prd = r_pend[k];
    end
  end

`ifdef WB_BYPASS_EN
  assign w_hit0 = r_rf_write & ~r_rf_set_quarter & (i_id_rs0 == r_rf_writeReg);
  assign w_hit1 = r_rf_write & ~r_rf_set_quarter & (i_id_rs1 == r_rf_writeReg);
  assign o_fwd0_hit  = w_hit0;
  assign o_fwd0_data = r_rf_writeData;
  assign o_fwd1_hit  = w_hit1;
  assign o_fwd1_data = r_rf_writeData;
`else
  assign w_hit0 = 1'b0;
  assign w_hit1 = 1'b0;
`endif

  assign o_hz_stall       = (w_p0 & ~w_hit0) | (w_p1 & ~w_hit1) | w_prd;
  assign o_ex_ready       = w_ready;
  assign o_rf_write       = r_rf_write;
  assign o_rf_writeReg    = r_rf_writeReg;
  assign o_rf_writeData   = r_rf_writeData;
  assign o_rf_set_quarter = r_rf_set_quarter;
  assign o_rf_qsel        = r_rf_qsel;
  assign o_err_spurious   = r_err_spurious;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Scoreboard bench for wb_stage: directed scenarios then random
//            traffic against a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

  localparam int QDEPTH = 2;
  localparam int NREG   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_is_load, ex_quarter;
  logic [3:0]  ex_dest;
  logic [15:0] ex_data;
  logic [1:0]  ex_qsel;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        rf_write, rf_set_quarter;
  logic [3:0]  rf_writeReg;
  logic [15:0] rf_writeData;
  logic [1:0]  rf_qsel;
  logic [3:0]  id_rs0, id_rs1, id_rd;
  logic        hz_stall, err_spurious;
`ifdef WB_BYPASS_EN
  logic        fwd0_hit, fwd1_hit;
  logic [15:0] fwd0_data, fwd1_data;
`endif

  always #5 clk = ~clk;

  wb_stage #(.QDEPTH(QDEPTH), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ex_valid(ex_valid), .o_ex_ready(ex_ready), .i_ex_is_load(ex_is_load),
    .i_ex_dest(ex_dest), .i_ex_data(ex_data), .i_ex_quarter(ex_quarter),
    .i_ex_qsel(ex_qsel), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_rf_write(rf_write), .o_rf_writeReg(rf_writeReg),
    .o_rf_writeData(rf_writeData), .o_rf_set_quarter(rf_set_quarter),
    .o_rf_qsel(rf_qsel), .i_id_rs0(id_rs0), .i_id_rs1(id_rs1), .i_id_rd(id_rd),
`ifdef WB_BYPASS_EN
    .o_fwd0_hit(fwd0_hit), .o_fwd0_data(fwd0_data),
    .o_fwd1_hit(fwd1_hit), .o_fwd1_data(fwd1_data),
`endif
    .o_hz_stall(hz_stall), .o_err_spurious(err_spurious)
  );

  typedef struct packed {
    logic [3:0]  dest;
    logic [15:0] data;
    logic        q;
    logic [1:0]  qsel;
  } ent_t;

  int   total = 0;
  int   bad   = 0;
  ent_t exp_q[$];

  // reference model state
  ent_t mq[$];
  bit   m_ld_busy;
  ent_t m_ld;
  bit   m_pend[NREG];
  bit   m_err;
  int   m_clr;
  bit   m_cur_v;
  ent_t m_cur;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ld_busy = 1'b0;
    m_ld      = '0;
    m_err     = 1'b0;
    m_clr     = -1;
    m_cur_v   = 1'b0;
    m_cur     = '0;
    for (int k = 0; k < NREG; k++) m_pend[k] = 1'b0;
  endtask

  function automatic bit pend_of(input logic [3:0] r);
    return (int'(r) < NREG) ? m_pend[int'(r)] : 1'b0;
  endfunction

  // Monitor: every registered write must match the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rf_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(rf_writeReg), 32'hFFFF);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          check("rf_writeReg", 32'(rf_writeReg), 32'(e.dest));
          check("rf_writeData", 32'(rf_writeData), 32'(e.data));
          check("rf_set_quarter", 32'(rf_set_quarter), 32'(e.q));
          check("rf_qsel", 32'(rf_qsel), 32'(e.qsel));
        end
      end else if (exp_q.size() != 0) begin
        ent_t e;
        e = exp_q.pop_front();
        check("missing_write", 32'(rf_write), 32'(1));
      end
    end
  end

  // One cycle: drive just after a falling edge, check combinational
  // outputs, advance the model, then wait for the next falling edge.
  task automatic step(input bit v, input bit ld, input logic [3:0] dest,
                      input logic [15:0] data, input bit q, input logic [1:0] qsel,
                      input bit rv, input logic [15:0] rd,
                      input logic [3:0] rs0, input logic [3:0] rs1, input logic [3:0] rdd);
    bit   ready, acc, wr_v, consumed, hit0, hit1, stall;
    ent_t in_e, w;
    ex_valid = v; ex_is_load = ld; ex_dest = dest; ex_data = data;
    ex_quarter = q; ex_qsel = qsel; mem_rvalid = rv; mem_rdata = rd;
    id_rs0 = rs0; id_rs1 = rs1; id_rd = rdd;
    #1;
    ready = (mq.size() < QDEPTH) && !(ld && m_ld_busy);
    check("ex_ready", 32'(ex_ready), 32'(ready));
    hit0 = 1'b0;
    hit1 = 1'b0;
`ifdef WB_BYPASS_EN
    hit0 = m_cur_v && (rs0 == m_cur.dest) && !m_cur.q;
    hit1 = m_cur_v && (rs1 == m_cur.dest) && !m_cur.q;
    check("fwd0_hit", 32'(fwd0_hit), 32'(hit0));
    check("fwd1_hit", 32'(fwd1_hit), 32'(hit1));
    if (hit0) check("fwd0_data", 32'(fwd0_data), 32'(m_cur.data));
`endif
    stall = (pend_of(rs0) && !hit0) || (pend_of(rs1) && !hit1) || pend_of(rdd);
    check("hz_stall", 32'(hz_stall), 32'(stall));
    check("err_spurious", 32'(err_spurious), 32'(m_err));

    acc      = v && ready;
    in_e     = {dest, data, q, qsel};
    w        = '0;
    wr_v     = 1'b0;
    consumed = 1'b0;
    if (rv && m_ld_busy) begin
      w = {m_ld.dest, rd, m_ld.q, m_ld.qsel};
      wr_v = 1'b1;
      m_ld_busy = 1'b0;
    end else begin
      if (rv) m_err = 1'b1;
      if (mq.size() > 0) begin
        w = mq.pop_front();
        wr_v = 1'b1;
      end else if (acc && !ld) begin
        w = in_e;
        wr_v = 1'b1;
        consumed = 1'b1;
      end
    end
    if (m_clr >= 0) m_pend[m_clr] = 1'b0;
    m_clr = -1;
    if (acc) begin
      if (int'(dest) < NREG) m_pend[int'(dest)] = 1'b1;
      if (ld) begin
        m_ld = in_e;
        m_ld_busy = 1'b1;
      end else if (!consumed) begin
        mq.push_back(in_e);
      end
    end
    m_cur_v = wr_v && (int'(w.dest) < NREG);
    if (m_cur_v) begin
      m_cur = w;
      m_clr = int'(w.dest);
      exp_q.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] rs0);
    step(0, 0, 4'd0, 16'h0, 0, 2'd0, 0, 16'h0, rs0, 4'd15, 4'd15);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_is_load = 0; ex_dest = 0; ex_data = 0; ex_quarter = 0;
    ex_qsel = 0; mem_rvalid = 0; mem_rdata = 0; id_rs0 = 15; id_rs1 = 15; id_rd = 15;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_rf_write", 32'(rf_write), 32'(0));
    check("rst_rf_data", 32'(rf_writeData), 32'(0));
    check("rst_err", 32'(err_spurious), 32'(0));
    rst_n = 1'b1;

    // single ALU op, then stall on rs0=2 until the pending bit clears
    step(1, 0, 4'd2, 16'h1234, 0, 2'd0, 0, 16'h0, 4'd15, 4'd15, 4'd15);
    idle(4'd2);
    idle(4'd2);
    // load dest=5, second load refused while waiting, return 0xBEEF
    step(1, 1, 4'd5, 16'h0, 0, 2'd0, 0, 16'h0, 4'd5, 4'd15, 4'd15);
    idle(4'd5);
    step(1, 1, 4'd6, 16'h0, 0, 2'd0, 0, 16'h0, 4'd15, 4'd15, 4'd15);
    idle(4'd5);
    step(0, 0, 4'd0, 16'h0, 0, 2'd0, 1, 16'hBEEF, 4'd5, 4'd15, 4'd15);
    idle(4'd5);
    // load return and ALU op collide: reg3 first, reg1 next
    step(1, 1, 4'd3, 16'h0, 0, 2'd0, 0, 16'h0, 4'd15, 4'd15, 4'd15);
    step(1, 0, 4'd1, 16'h0111, 0, 2'd0, 1, 16'h00AA, 4'd15, 4'd15, 4'd15);
    idle(4'd1);
    idle(4'd1);
    // quarter write, then illegal dest
    step(1, 0, 4'd4, 16'h000F, 1, 2'd3, 0, 16'h0, 4'd15, 4'd15, 4'd15);
    step(1, 0, 4'd9, 16'h5555, 0, 2'd0, 0, 16'h0, 4'd9, 4'd15, 4'd15);
    idle(4'd15);
    // spurious return in IDLE
    step(0, 0, 4'd0, 16'h0, 0, 2'd0, 1, 16'h7777, 4'd15, 4'd15, 4'd15);
    idle(4'd15);
    // reset during LOAD_WAIT, then a late return is spurious
    step(1, 1, 4'd7, 16'h0, 0, 2'd0, 0, 16'h0, 4'd15, 4'd15, 4'd15);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rf_write", 32'(rf_write), 32'(0));
    check("midrst_rf_reg", 32'(rf_writeReg), 32'(0));
    check("midrst_rf_data", 32'(rf_writeData), 32'(0));
    check("midrst_rf_q", 32'({rf_set_quarter, rf_qsel}), 32'(0));
    check("midrst_err", 32'(err_spurious), 32'(0));
    check("midrst_stall", 32'(hz_stall), 32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 4'd0, 16'h0, 0, 2'd0, 1, 16'h1111, 4'd7, 4'd15, 4'd15);
    idle(4'd7);
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic; decode never issues a dest that is still pending
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] d;
      bit v, rv;
      d  = 4'($urandom_range(0, 11));
      v  = ($urandom_range(0, 3) != 0) && !pend_of(d);
      rv = m_ld_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      step(v, ($urandom_range(0, 2) == 0), d, 16'($urandom), $urandom_range(0, 1) == 1,
           2'($urandom), rv, 16'($urandom), 4'($urandom_range(0, 9)),
           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 4'd0, 16'h0, 0, 2'd0, m_ld_busy, 16'hA5A5, 4'd15, 4'd15, 4'd15);
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
